// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8-bit UART transmitter, LSB first.
// Bytes from single-cycle strobes are queued in a FIFO.
// The serializer pops one byte per frame and sends 8N1.
// Define UART_TX_PARITY_EN to add an even-parity bit before stop (8E1).
module uart_tx_fifo #(
  parameter int CLK_FRE    = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_vld,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          ovf_err
);

  localparam int BAUD_CNT_MAX = CLK_FRE / BAUD_RATE;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int BW           = $clog2(BAUD_CNT_MAX + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT_MAX - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4
  } state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   cnt_reg, cnt_next;
  state_t        state_reg, state_next;
  logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;
  logic          busy_reg, busy_next;
  logic          ovf_reg;
  logic          bit_end, push, pop;

  // Full is judged on the registered count, so a write while full is
  // rejected even when a pop frees a slot on the same edge.
  assign fifo_full = (cnt_reg == DEPTH_CNT);
  assign bit_end   = (baud_cnt_reg == BAUD_LAST);
  assign push      = tx_vld & ~fifo_full;
  assign pop       = (cnt_reg != '0) &
                     ((state_reg == IDLE) | ((state_reg == STOP) & bit_end));

  assign tx       = tx_reg;
  assign tx_busy  = busy_reg;
  assign fifo_cnt = cnt_reg;
  assign ovf_err  = ovf_reg;

  // FIFO storage: plain array, no reset, so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= tx_data;
  end

  // Next-state logic of the frame sequencer
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (pop) state_next = START;
      START: if (bit_end) state_next = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && bit_idx_reg == 3'd7) state_next = PARITY;
      PARITY: if (bit_end) state_next = STOP;
`else
      DATA:  if (bit_end && bit_idx_reg == 3'd7) state_next = STOP;
`endif
      STOP:  if (bit_end) state_next = pop ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath next values: bit timer, bit index, shift register, occupancy
  always_comb begin
    baud_cnt_next = (state_reg == IDLE || bit_end) ? '0 : baud_cnt_reg + 1'b1;
    bit_idx_next  = 3'd0;
    if (state_reg == DATA) bit_idx_next = bit_end ? bit_idx_reg + 3'd1 : bit_idx_reg;
    shift_next = pop ? mem[rd_ptr_reg] : shift_reg;
    cnt_next   = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  // Output logic: line level and busy are computed from the upcoming state
  // so the registered pins line up with the state they describe.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:  tx_next = 1'b0;
      DATA:   tx_next = shift_next[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_next = ^shift_next;
`endif
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE) | (cnt_next != '0);
  end

  // State, pointers, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      cnt_reg      <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (tx_vld && fifo_full) ovf_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// Each accepted byte gets an expected start edge from an arithmetic
// timing model; a line monitor decodes frames and compares.
module tb_uart_tx_fifo;
  localparam int CLK_FRE   = 1_000_000;
  localparam int BAUD_RATE = 83_333;
  localparam int DEPTH     = 16;
  localparam int BAUD      = CLK_FRE / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * BAUD;
`else
  localparam int FRAME = 10 * BAUD;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic tx_vld = 1'b0;
  logic tx, tx_busy, fifo_full, ovf_err;
  logic [$clog2(DEPTH):0] fifo_cnt;

  uart_tx_fifo #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_vld(tx_vld), .tx(tx),
    .tx_busy(tx_busy), .fifo_full(fifo_full), .fifo_cnt(fifo_cnt), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int w; int s; logic [7:0] d; } ent_t;
  ent_t hist[$];
  ent_t sbq[$];
  int total = 0, bad = 0;
  int last_start = -1000000;
  int ovf_edge = 1 << 30;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Occupancy after edge n: bytes written by n minus bytes popped by n
  function automatic int cnt_model(input int n);
    int c = 0;
    foreach (hist[i]) begin
      if (hist[i].w <= n) c++;
      if (hist[i].s <= n) c--;
    end
    return c;
  endfunction

  // Busy after edge n: some byte is written but its frame is not finished
  function automatic int busy_model(input int n);
    foreach (hist[i])
      if (hist[i].w <= n && n < hist[i].s + FRAME) return 1;
    return 0;
  endfunction

  function automatic logic exp_bit(input logic [7:0] d, input int pos);
    int b = pos / BAUD;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Per-cycle status checker
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      int ec;
      ec = cnt_model(cyc);
      check("fifo_cnt", int'(fifo_cnt), ec);
      check("fifo_full", int'(fifo_full), int'(ec == DEPTH));
      check("tx_busy", int'(tx_busy), busy_model(cyc));
      check("ovf_err", int'(ovf_err), int'(cyc >= ovf_edge));
    end
  end

  // Line monitor: decode frames and compare with the scoreboard
  bit in_frame = 1'b0;
  int pos = 0, fbad = 0, fstart = 0;
  logic [7:0] cur = 8'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx == 1'b0) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame: start seen at cycle %0d, required no frame", cyc);
          cur = 8'h00;
        end else begin
          ent_t e;
          e = sbq.pop_front();
          check("start_cycle", cyc, e.s);
          cur = e.d;
        end
        in_frame = 1'b1; pos = 0; fbad = 0; fstart = cyc;
      end
      if (in_frame) begin
        if (tx !== exp_bit(cur, pos)) fbad++;
        pos++;
        if (pos == FRAME) begin
          check($sformatf("frame_%02h_bad_cycles", cur), fbad, 0);
          $display("frame data=%02h start=%0d bad_cycles=%0d", cur, fstart, fbad);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic wr(input logic [7:0] d);
    int k = cyc + 1;
    if (cnt_model(cyc) < DEPTH) begin
      ent_t e;
      e.w = k;
      e.s = (last_start + FRAME > k + 1) ? last_start + FRAME : k + 1;
      e.d = d;
      last_start = e.s;
      hist.push_back(e);
      sbq.push_back(e);
    end else if (ovf_edge > k) begin
      ovf_edge = k;
    end
    tx_data = d;
    tx_vld  = 1'b1;
    @(negedge clk);
    tx_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || in_frame) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", int'(t < 20000), 1);
    idle(3);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s1;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(tx_busy), 0);
    check("rst_cnt", int'(fifo_cnt), 0);
    check("rst_full", int'(fifo_full), 0);
    check("rst_ovf", int'(ovf_err), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // single byte: count 1 after write edge, start bit one edge later
    wr(8'h41);
    check("lat_cnt", int'(fifo_cnt), 1);
    check("lat_tx_idle", int'(tx), 1);
    idle(1);
    check("lat_tx_start", int'(tx), 0);
    drain();

    // burst on consecutive cycles, frames back-to-back
    wr(8'h41); wr(8'h54); wr(8'h0d); wr(8'h0a);
    check("burst_cnt", int'(fifo_cnt), 3);
    drain();

    // write on the STOP-end pop edge with one byte queued
    wr(8'h11); s1 = last_start; wr(8'h22);
    wait_until(s1 + FRAME - 1);
    wr(8'h33);
    check("stop_pop_cnt", int'(fifo_cnt), 1);
    drain();

    // write on the last STOP cycle into an empty FIFO: one idle cycle
    wr(8'h5a); s1 = last_start;
    wait_until(s1 + FRAME - 1);
    wr(8'ha5);
    drain();

    // overflow: 17 writes while a prior frame is in START
    wr(8'h01);
    idle(2);
    for (int i = 0; i < 17; i++) wr(8'h80 + 8'(i));
    check("ovf_full", int'(fifo_full), 1);
    check("ovf_flag", int'(ovf_err), 1);
    drain();

    // parity-relevant patterns
    wr(8'h07); wr(8'h03);
    drain();

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      wr(8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
      else idle($urandom_range(0, 2 * FRAME));
    end
    drain();

    // reset in the middle of data bit 3
    wr(8'hc3); s1 = last_start;
    wait_until(s1 + 4 * BAUD + BAUD / 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", int'(tx), 1);
    check("mid_rst_cnt", int'(fifo_cnt), 0);
    check("mid_rst_busy", int'(tx_busy), 0);
    check("mid_rst_ovf", int'(ovf_err), 0);
    hist.delete();
    sbq.delete();
    last_start = -1000000;
    ovf_edge = 1 << 30;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("post_rst_tx", int'(tx), 1);
    wr(8'h55);
    drain();

    check("leftover_expected", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8-bit UART transmitter that sits directly downstream of the ESP8266 controller's command/data byte output and drives the physical TX pin toward the WiFi module. It accepts single-cycle byte strobes into a small FIFO, serializes each byte LSB-first as 8N1, or 8E1 when parity is enabled, and reports occupancy and overflow. The FIFO absorbs pacing mismatch between the upstream byte strobes and the serializer.

## Interface
- `CLK_FRE`, default 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, default 115200, line rate in bit/s.
- `FIFO_DEPTH`, default 16, FIFO entries. Must be a power of two, minimum 4.
- `BAUD_CNT_MAX` (local), value `CLK_FRE / BAUD_RATE` using integer division, 434 at defaults; clock cycles per bit.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tx_data` in 8: byte to transmit.
- `tx_vld` in 1: one-cycle write strobe for `tx_data`.
- `tx` out 1: serial line. Idles high.
- `tx_busy` out 1: high while the FIFO is non-empty or a frame is in progress.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `fifo_cnt` out log2(FIFO_DEPTH)+1: current occupancy.
- `ovf_err` out 1: sticky flag, set when a write is dropped; cleared only by reset.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `fifo_full`=0, `fifo_cnt`=0, `ovf_err`=0. FSM state is IDLE; all pointers and counters are 0.
- **Write:**
  - When `tx_vld`=1 and `fifo_full`=0, the byte is stored at the write pointer.
  - When `tx_vld`=1 and `fifo_full`=1, the byte is dropped and `ovf_err` is set.
  - `fifo_full` is evaluated on the pre-edge count. A write while full is rejected even if a pop occurs in the same cycle.
- **Pop:**
  - Occurs in IDLE when the FIFO is non-empty.
  - Occurs on the last cycle of STOP when the FIFO is non-empty.
  - The popped byte is latched into an 8-bit shift register.
- **Simultaneous push and pop** (not full): both take effect and `fifo_cnt` is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`. `fifo_cnt` ranges from 0 to `FIFO_DEPTH`.
- **FSM states:** IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE → START on pop.
  - START → DATA after `BAUD_CNT_MAX` cycles.
  - DATA → PARITY (or STOP) after 8 bits.
  - PARITY → STOP after 1 bit.
  - STOP → START if a pop occurs on the last STOP cycle; otherwise STOP → IDLE.
- **Bit timer:**
  - Counts 0..`BAUD_CNT_MAX`-1 and restarts at 0 on every bit boundary.
  - Held at 0 in IDLE.
- **Bit index:** counts 0..7 in DATA and is cleared on entry to DATA.
- **`tx` levels:**
  - START: 0.
  - DATA: shift-register bit[index], LSB first.
  - PARITY: parity bit.
  - STOP and IDLE: 1.
- `tx` is registered and has no combinational path from the inputs.
- `tx_busy` = (state != IDLE) | (`fifo_cnt` != 0), registered.

## Timing
- Latency: `tx_vld` sampled at edge k with FIFO empty and state IDLE → `fifo_cnt`=1 after edge k → pop and `tx`=0 after edge k+1.
- Each bit lasts exactly `BAUD_CNT_MAX` cycles.
- Frame length is 10×`BAUD_CNT_MAX` cycles, or 11×`BAUD_CNT_MAX` with parity.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle, with no extra idle cycle.
- A write on the last STOP cycle into an empty FIFO is not popped that cycle. The FSM goes to IDLE and pops on the following cycle, so the line idles high for 1 cycle.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronous) and the FIFO contents are discarded. After release, the block stays in IDLE until a new write.
- `fifo_full` and `fifo_cnt` update on the edge after the push or pop.

## Configuration
- Macro `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in and one even-parity bit (XOR of the 8 data bits) is sent between the last data bit and stop. Frame is 11 bits.
  - Undefined: no PARITY state or logic. Frame is 10 bits (8N1), as required by the ESP8266 AT link at default settings.

## Test plan
- Single byte 0x41, FIFO empty, no parity:
  - `tx`=0 one cycle after the strobe.
  - Then bits 1,0,0,0,0,0,1,0, then 1, each 434 cycles.
  - `tx_busy` falls the cycle after the stop bit ends.
- Burst "AT\r\n" written on 4 consecutive cycles:
  - `fifo_cnt` reaches 3 (1 popped immediately).
  - Four frames are sent back-to-back, total 4×4340 cycles, with no idle gaps.
- Overflow:
  - 17 writes start on consecutive cycles while `tx` is in START of a prior frame, with `FIFO_DEPTH`=16 and the FIFO empty.
  - The first 16 are accepted, `fifo_full`=1, and `ovf_err`=1 after the 17th.
  - The 17th byte is never transmitted.
- Write on the same cycle as the STOP-end pop, with `fifo_cnt`=1: `fifo_cnt` stays 1 and both bytes are sent in order.
- Reset pulse at mid DATA bit 3:
  - `tx`=1, `fifo_cnt`=0, `tx_busy`=0 immediately.
  - A subsequent write of 0x55 transmits a clean frame.
- With `UART_TX_PARITY_EN`:
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Frames are 4774 cycles.
